// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter in front of an eight-entry register bank.
// Grants at most one pending write per cycle and exposes the bank on a combinational read port.
module reg_bank_arbiter #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [4*AW-1:0]    wr_addr,
    input  logic [4*WIDTH-1:0] wr_data,
    output logic [3:0]         ack,
    input  logic [AW-1:0]      raddr,
    output logic [WIDTH-1:0]   rdata,
    output logic [1:0]         last_grant,
    output logic [15:0]        wr_count
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] bank_r [DEPTH];
    logic [1:0]       ptr_r;
    logic [1:0]       last_grant_r;
    logic [15:0]      wr_count_r;

    logic [3:0]       rot_s;
    logic [1:0]       off_s;
    logic [1:0]       winner_s;
    logic             grant_s;
    logic [3:0]       ack_s;
    logic [AW-1:0]    sel_addr_s;
    logic [WIDTH-1:0] sel_data_s;

    // Rotate requests so bit 0 is the requester currently holding top priority.
    always_comb begin
        rot_s = req;
        case (ptr_r)
            2'd0:    rot_s = req;
            2'd1:    rot_s = {req[0], req[3:1]};
            2'd2:    rot_s = {req[1:0], req[3:2]};
            2'd3:    rot_s = {req[2:0], req[3]};
            default: rot_s = req;
        endcase
    end

    // Priority-encode the rotated vector, then map the offset back to a requester index.
    always_comb begin
        off_s   = 2'd0;
        grant_s = 1'b1;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: begin
                off_s   = 2'd0;
                grant_s = 1'b0;
            end
        endcase
        winner_s = ptr_r + off_s;
    end

    // Acknowledge is gated by reset so an in-flight grant vanishes the moment reset rises.
    always_comb begin
        ack_s = 4'b0000;
        if (grant_s && !reset) begin
            ack_s = 4'b0001 << winner_s;
        end else begin
            ack_s = 4'b0000;
        end
    end

    // Route the winning requester's address and payload to the bank write port.
    always_comb begin
        sel_addr_s = wr_addr[0 +: AW];
        sel_data_s = wr_data[0 +: WIDTH];
        case (winner_s)
            2'd0: begin
                sel_addr_s = wr_addr[0*AW +: AW];
                sel_data_s = wr_data[0*WIDTH +: WIDTH];
            end
            2'd1: begin
                sel_addr_s = wr_addr[1*AW +: AW];
                sel_data_s = wr_data[1*WIDTH +: WIDTH];
            end
            2'd2: begin
                sel_addr_s = wr_addr[2*AW +: AW];
                sel_data_s = wr_data[2*WIDTH +: WIDTH];
            end
            2'd3: begin
                sel_addr_s = wr_addr[3*AW +: AW];
                sel_data_s = wr_data[3*WIDTH +: WIDTH];
            end
            default: begin
                sel_addr_s = wr_addr[0 +: AW];
                sel_data_s = wr_data[0 +: WIDTH];
            end
        endcase
    end

    // Bank storage: single write port, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_r[i] <= {WIDTH{1'b0}};
            end
        end else if (grant_s) begin
            bank_r[sel_addr_s] <= sel_data_s;
        end
    end

    // Priority pointer, last-grant index and commit counter advance only on a grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r        <= 2'd0;
            last_grant_r <= 2'd0;
            wr_count_r   <= 16'd0;
        end else if (grant_s) begin
            ptr_r        <= winner_s + 2'd1;
            last_grant_r <= winner_s;
            wr_count_r   <= wr_count_r + 16'd1;
        end
    end

    assign ack        = ack_s;
    assign rdata      = bank_r[raddr];
    assign last_grant = last_grant_r;
    assign wr_count   = wr_count_r;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed scenarios plus randomized traffic
// against a queue-free reference model of round-robin arbitration and the bank contents.
module tb_reg_bank_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] wr_addr;
    logic [63:0] wr_data;
    logic [3:0]  ack;
    logic [2:0]  raddr;
    logic [15:0] rdata;
    logic [1:0]  last_grant;
    logic [15:0] wr_count;

    int vectors;
    int miscompares;

    logic [15:0] m_bank [8];
    int          m_ptr;
    int          m_last;
    int          m_count;

    reg_bank_arbiter #(.WIDTH(16), .AW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ack        (ack),
        .raddr      (raddr),
        .rdata      (rdata),
        .last_grant (last_grant),
        .wr_count   (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int model_winner(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ack(input logic [3:0] r);
        int w;
        w = model_winner(r);
        if (w < 0) return 4'b0000;
        return 4'b0001 << w;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_bank[i] = 16'h0000;
        m_ptr   = 0;
        m_last  = 0;
        m_count = 0;
    endtask

    // Drive inputs just after a rising edge and return at the following falling edge.
    task automatic drive(input logic [3:0] r, input logic [11:0] a, input logic [63:0] d, input logic [2:0] ra);
        req     = r;
        wr_addr = a;
        wr_data = d;
        raddr   = ra;
        @(negedge clk);
    endtask

    // Advance one rising edge and apply the same write to the model.
    task automatic tick();
        int w;
        w = model_winner(req);
        @(posedge clk);
        if (w >= 0) begin
            m_bank[wr_addr[w*3 +: 3]] = wr_data[w*16 +: 16];
            m_ptr   = (w + 1) % 4;
            m_last  = w;
            m_count = (m_count + 1) % 65536;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        #2;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        req     = 4'b1111;
        wr_addr = 12'hFFF;
        wr_data = 64'hDEAD_BEEF_CAFE_F00D;
        model_clear();
        for (int i = 0; i < 8; i++) begin
            raddr = 3'(i);
            #1;
            vectors++;
            if (rdata !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_rdata[%0d]: got %h expected 0000", i, rdata);
            end
        end
        vectors++;
        if (ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ack: got %b expected 0000", ack);
        end
        vectors++;
        if (wr_count !== 16'd0 || last_grant !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got cnt=%h lg=%0d expected cnt=0000 lg=0", wr_count, last_grant);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        do_reset();
        drive(4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, {16'h0, 16'hBEEF, 16'h0, 16'h0}, 3'd5);
        vectors++;
        if (ack !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_ack: got %b expected 0100", ack);
        end
        tick();
        drive(4'b0000, 12'h000, 64'h0, 3'd5);
        vectors++;
        if (rdata !== 16'hBEEF || last_grant !== 2'd2 || wr_count !== 16'd1) begin
            miscompares++;
            $display("FAIL single_commit: got rdata=%h lg=%0d cnt=%0d expected BEEF 2 1", rdata, last_grant, wr_count);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [8];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 12'($urandom), {$urandom, $urandom}, 3'($urandom));
            vectors++;
            if (ack !== seq[i]) begin
                miscompares++;
                $display("FAIL rr_ack[%0d]: got %b expected %b", i, ack, seq[i]);
            end
            tick();
        end
        drive(4'b0000, 12'h000, 64'h0, 3'd0);
        vectors++;
        if (wr_count !== 16'd8 || last_grant !== 2'd3) begin
            miscompares++;
            $display("FAIL rr_count: got cnt=%0d lg=%0d expected 8 3", wr_count, last_grant);
        end
        tick();
    endtask

    task automatic test_pointer_skip();
        logic [3:0] rq  [3];
        logic [3:0] exp [3];
        rq  = '{4'b1001, 4'b1001, 4'b0001};
        exp = '{4'b0001, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(rq[i], 12'($urandom), {$urandom, $urandom}, 3'd0);
            vectors++;
            if (ack !== exp[i]) begin
                miscompares++;
                $display("FAIL skip_ack[%0d]: got %b expected %b", i, ack, exp[i]);
            end
            tick();
        end
        vectors++;
        if (last_grant !== 2'd0 || wr_count !== 16'd3) begin
            miscompares++;
            $display("FAIL skip_state: got lg=%0d cnt=%0d expected 0 3", last_grant, wr_count);
        end
    endtask

    task automatic test_collision();
        logic [11:0] a;
        logic [63:0] d;
        a = {3'd7, 3'd0, 3'd7, 3'd0};
        d = {16'h3333, 16'h0000, 16'h1111, 16'h0000};
        do_reset();
        drive(4'b1010, a, d, 3'd7);
        vectors++;
        if (ack !== 4'b0010 || rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL coll_first: got ack=%b rdata=%h expected 0010 0000", ack, rdata);
        end
        tick();
        drive(4'b1000, a, d, 3'd7);
        vectors++;
        if (ack !== 4'b1000 || rdata !== 16'h1111) begin
            miscompares++;
            $display("FAIL coll_second: got ack=%b rdata=%h expected 1000 1111", ack, rdata);
        end
        tick();
        drive(4'b0000, a, d, 3'd7);
        vectors++;
        if (rdata !== 16'h3333) begin
            miscompares++;
            $display("FAIL coll_final: got %h expected 3333", rdata);
        end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(4'b0100, {3'd0, 3'd3, 3'd0, 3'd0}, {16'h0, 16'h1234, 16'h0, 16'h0}, 3'd3);
        tick();
        drive(4'b0010, {3'd0, 3'd0, 3'd6, 3'd0}, {16'h0, 16'h0, 16'hABCD, 16'h0}, 3'd6);
        vectors++;
        if (ack !== 4'b0010 || wr_count !== 16'd1) begin
            miscompares++;
            $display("FAIL areset_pre: got ack=%b cnt=%0d expected 0010 1", ack, wr_count);
        end
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        vectors++;
        if (ack !== 4'b0000 || wr_count !== 16'd0 || last_grant !== 2'd0 || rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL areset_now: got ack=%b cnt=%0d lg=%0d rdata=%h expected 0000 0 0 0000", ack, wr_count, last_grant, rdata);
        end
        raddr = 3'd3;
        #1;
        vectors++;
        if (rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL areset_bank: got %h expected 0000", rdata);
        end
        reset   = 1'b0;
        req     = 4'b1111;
        wr_addr = {3'd1, 3'd1, 3'd1, 3'd1};
        wr_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        raddr   = 3'd6;
        #1;
        vectors++;
        if (ack !== 4'b0001 || rdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL areset_release: got ack=%b rdata6=%h expected 0001 0000", ack, rdata);
        end
        tick();
        raddr = 3'd1;
        req   = 4'b0000;
        #1;
        vectors++;
        if (wr_count !== 16'd1 || last_grant !== 2'd0 || rdata !== 16'h1111) begin
            miscompares++;
            $display("FAIL areset_after: got cnt=%0d lg=%0d rdata=%h expected 1 0 1111", wr_count, last_grant, rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [3:0]  pend;
        logic [11:0] a;
        logic [63:0] d;
        int          w;
        pend = 4'b0000;
        a    = 12'h000;
        d    = 64'h0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pend[i]         = 1'b1;
                        a[i*3 +: 3]     = 3'($urandom);
                        d[i*16 +: 16]   = 16'($urandom);
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            drive(pend, a, d, 3'($urandom));
            vectors++;
            if (ack !== exp_ack(req) || rdata !== m_bank[raddr]) begin
                miscompares++;
                $display("FAIL rand_comb[%0d]: got ack=%b rdata=%h expected %b %h", c, ack, rdata, exp_ack(req), m_bank[raddr]);
            end
            w = model_winner(req);
            tick();
            vectors++;
            if (last_grant !== 2'(m_last) || wr_count !== 16'(m_count)) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: got lg=%0d cnt=%0d expected %0d %0d", c, last_grant, wr_count, m_last, m_count);
            end
            if (w >= 0) pend[w] = 1'b0;
        end
    endtask

    task automatic test_wrap();
        while (m_count != 65535) begin
            req     = 4'b1111;
            wr_addr = {3'd2, 3'd2, 3'd2, 3'd2};
            wr_data = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
            tick();
        end
        drive(4'b0001, {3'd0, 3'd0, 3'd0, 3'd4}, {16'h0, 16'h0, 16'h0, 16'h5A5A}, 3'd4);
        vectors++;
        if (wr_count !== 16'hFFFF || ack !== exp_ack(req)) begin
            miscompares++;
            $display("FAIL wrap_pre: got cnt=%h ack=%b expected FFFF %b", wr_count, ack, exp_ack(req));
        end
        tick();
        drive(4'b0000, 12'h000, 64'h0, 3'd4);
        vectors++;
        if (wr_count !== 16'h0000 || rdata !== 16'h5A5A || last_grant !== 2'd0) begin
            miscompares++;
            $display("FAIL wrap_post: got cnt=%h rdata=%h lg=%0d expected 0000 5A5A 0", wr_count, rdata, last_grant);
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        req         = 4'b0000;
        wr_addr     = 12'h000;
        wr_data     = 64'h0;
        raddr       = 3'd0;
        #1;
        test_reset();
        test_single_write();
        test_round_robin();
        test_pointer_skip();
        test_collision();
        test_async_reset();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Write arbiter and storage for a shared bank of eight 16-bit registers used by up to four requesters (CPU write-back, DMA, debug port, I/O latch). Each cycle it grants at most one pending write under round-robin priority, commits that write to the bank, and acknowledges the winner. A combinational read port exposes any bank entry. It sits between the requesters and the register storage and is the only writer of that storage.

## Interface
Parameters:
- WIDTH, 16, data width of each bank entry and write payload
- AW, 3, bank address width (bank depth = 2**AW = 8)

Ports:
- clk  input  1  rising-edge clock for all state
- reset  input  1  asynchronous, active-high; clears all state immediately
- req  input  4  req[i] = requester i has a pending write
- wr_addr  input  4*AW  requester i address at bits [i*AW +: AW]
- wr_data  input  4*WIDTH  requester i payload at bits [i*WIDTH +: WIDTH]
- ack  output  4  one-hot or zero; ack[i] = requester i's write commits at this clock edge
- raddr  input  AW  read address
- rdata  output  WIDTH  bank[raddr], combinational
- last_grant  output  2  index of the most recently granted requester (registered)
- wr_count  output  16  number of committed writes, wraps at 16'hFFFF -> 0

## Operation
- State: bank[0..7] (WIDTH each), priority pointer ptr (2 bits), last_grant, wr_count.
- Reset values: bank all 0, ptr = 0, last_grant = 0, wr_count = 0; ack = 0 while reset is high; rdata = 0.
- Arbitration is combinational. Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4), and the first i with req[i] = 1 wins.
- ack = one-hot of the winner. If req = 0, ack = 0.
- On the clock edge with winner w:
  - bank[wr_addr_w] <= wr_data_w
  - ptr <= (w+1) mod 4
  - last_grant <= w
  - wr_count <= wr_count + 1, mod 2^16
- No winner: ptr, last_grant, wr_count and bank hold.
- Handshake:
  - A requester holds req, wr_addr and wr_data stable until it samples ack = 1 at a clock edge.
  - Deasserting req before ack withdraws the write with no effect.
  - Keeping req high after ack is a new, separate write request.
- Fairness: a continuously requesting requester is granted within 4 cycles.
- Different requesters targeting the same address serialize in grant order, and the last grant's data wins.
- At most one bank write per cycle. ack is never multi-hot.

## Timing
- Write latency: commit at the edge where ack is high. The new value is visible on rdata in the next cycle when raddr matches.
- Read in the same cycle as a write to the same address returns the old value (no bypass).
- ack depends combinationally on req and ptr. There is no registered delay, so a grant costs zero bubble cycles, and back-to-back grants give 1 write/cycle.
- reset asserted mid-operation:
  - ack drops to 0 immediately, and the in-flight write does not commit.
  - All state returns to reset values without waiting for clk.
- reset deassertion: first possible grant is at the first rising edge after deassertion, to the lowest-index requester (ptr = 0).
- wr_count wraps silently. No overflow flag.

## Test plan
- Reset then single write: req = 4'b0100, wr_addr2 = 5, wr_data2 = 16'hBEEF -> ack = 4'b0100 that cycle; next cycle raddr = 5 gives rdata = 16'hBEEF, last_grant = 2, wr_count = 1.
- Round-robin rotation: req = 4'b1111 held for 8 cycles from reset -> ack sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000; wr_count = 8.
- Pointer skip: ptr = 0, req = 4'b1001 for 2 cycles -> grants to 0, then 3; next req = 4'b0001 -> grant to 0.
- Same-address collision: requesters 1 and 3 both write addr 7 (16'h1111, 16'h3333), ptr = 0 -> grant order 1 then 3; final rdata at addr 7 = 16'h3333. A read of addr 7 in the cycle requester 3 commits returns 16'h1111.
- Async reset mid-write: req = 4'b0010 with ack high, pulse reset between edges -> ack = 0 immediately; bank entry unchanged (0); wr_count = 0, ptr = 0.
- wr_count wrap: preload via 65535 single writes, then one more -> wr_count goes 16'hFFFF -> 16'h0000, bank updated normally.
